// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory fetch arbiter.
// Holds the FSM state encoding, requester IDs and the round-robin pick rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic       REQ_IF        = 1'b0;
  localparam logic       REQ_LS        = 1'b1;
  localparam logic [3:0] IF_READ_BYTES = 4'd4;

  // Returns the requester ID to grant; on a tie the one that did not win last time.
  function automatic logic pick_requester(input logic if_req,
                                          input logic ls_req,
                                          input logic last_grant);
    logic pick;
    if (if_req && ls_req) begin
      pick = ~last_grant;
    end else if (ls_req) begin
      pick = REQ_LS;
    end else begin
      pick = REQ_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for the memory handshake; flags the cycle on which a
// transfer has waited TIMEOUT cycles without completing. TIMEOUT=0 disables it.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic           WD_ON    = (TIMEOUT > 0);

  logic [CNT_W-1:0] wait_cnt_r;

  // Counts waiting cycles, saturating at the abort point so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (enable && (wait_cnt_r != LAST_CNT)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign expired = WD_ON && enable && (wait_cnt_r == LAST_CNT);

endmodule

// File: rtl/mem_fetch_arbiter.sv
// Shares one SPI memory controller between instruction fetch and load requests:
// round-robin grant, level start/done handshake, word capture, idle gap and watchdog abort.
module mem_fetch_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  output logic              if_err,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [3:0]        ls_bytes,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_data,
  output logic              ls_err,
  output logic              mem_start_request,
  output logic              mem_is_data_fetch,
  output logic [ADDR_W-1:0] mem_target_address,
  output logic [3:0]        mem_read_bytes,
  input  logic [DATA_W-1:0] mem_fetched_instruction,
  input  logic [DATA_W-1:0] mem_fetched_data,
  input  logic              mem_request_done
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             last_grant_r;
  logic             grant_s;
  logic             grant_ls_s;
  logic             finish_s;
  logic             abort_s;
  logic             end_s;
  logic             waiting_s;
  logic             expired_s;

  assign waiting_s = (state_r == WAIT);
  assign end_s     = finish_s | abort_s;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_s),
    .enable  (waiting_s),
    .expired (expired_s)
  );

  // Next-state and event decode; a done in the expiry cycle counts as normal completion.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    finish_s    = 1'b0;
    abort_s     = 1'b0;
    grant_ls_s  = pick_requester(if_req, ls_req, last_grant_r);
    case (state_r)
      IDLE: begin
        if (if_req || ls_req) begin
          grant_s     = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (mem_request_done) begin
          finish_s    = 1'b1;
          state_nxt_s = GAP;
        end else if (expired_s) begin
          abort_s     = 1'b1;
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and gap-length counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  // Controller-side registers: latched at grant, start held until completion or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_start_request  <= 1'b0;
      mem_is_data_fetch  <= 1'b0;
      mem_target_address <= {ADDR_W{1'b0}};
      mem_read_bytes     <= 4'd0;
      last_grant_r       <= REQ_IF;
    end else if (grant_s) begin
      mem_start_request  <= 1'b1;
      mem_is_data_fetch  <= grant_ls_s;
      mem_target_address <= (grant_ls_s == REQ_LS) ? ls_addr : if_addr;
      mem_read_bytes     <= (grant_ls_s == REQ_LS) ? ls_bytes : IF_READ_BYTES;
      last_grant_r       <= grant_ls_s;
    end else if (end_s) begin
      mem_start_request <= 1'b0;
    end else begin
      mem_start_request <= mem_start_request;
    end
  end

  // Requester-side results: one-cycle done pulse, error flag and held data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      if_data <= {DATA_W{1'b0}};
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      ls_data <= {DATA_W{1'b0}};
    end else begin
      if_done <= end_s && (mem_is_data_fetch == REQ_IF);
      ls_done <= end_s && (mem_is_data_fetch == REQ_LS);
      if (end_s && (mem_is_data_fetch == REQ_IF)) begin
        if_err <= abort_s;
      end else begin
        if_err <= if_err;
      end
      if (end_s && (mem_is_data_fetch == REQ_LS)) begin
        ls_err <= abort_s;
      end else begin
        ls_err <= ls_err;
      end
      if (finish_s && (mem_is_data_fetch == REQ_IF)) begin
        if_data <= mem_fetched_instruction;
      end else begin
        if_data <= if_data;
      end
      if (finish_s && (mem_is_data_fetch == REQ_LS)) begin
        ls_data <= mem_fetched_data;
      end else begin
        ls_data <= ls_data;
      end
    end
  end

endmodule
